// File: rtl/dt_stack_seq.sv
// Request sequencer that drives a data-stack command/ack port and tracks its depth.
// Define DT_STACK_GUARD_EN to block PUSH-when-full / POP-when-empty and raise a sticky err.
module dt_stack_seq #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 5
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [1:0]        req_cnt,
   input  logic [DATA_W-1:0] req_data,
   output logic [1:0]        dt_cmd,
   output logic [DATA_W-1:0] dt_data,
   input  logic              dt_ack,
   output logic [CNT_W-1:0]  dt_depth,
   output logic              dt_empty,
   output logic              dt_full,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
   typedef enum logic [1:0] {
      CMD_NON = 2'd0,
      CMD_PUS = 2'd1,
      CMD_POP = 2'd2,
      CMD_CLR = 2'd3
   } cmd_t;

   localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(DEPTH);

   state_t              state;
   logic [1:0]          op_q;
   logic [1:0]          cnt_q;
   logic [DATA_W-1:0]   data_q;
   logic [CNT_W-1:0]    depth;
   logic                guard_hit;

   assign req_ready = (state == IDLE);
   assign dt_depth  = depth;
   assign dt_empty  = (depth == '0);
   assign dt_full   = (depth == DEPTH_MAX);

   // Guard is evaluated for the op about to enter ISSUE: the new request from IDLE, or a POP repeat from GAP.
`ifdef DT_STACK_GUARD_EN
   logic [1:0] entry_op;
   assign entry_op  = (state == IDLE) ? req_op : op_q;
   assign guard_hit = (entry_op == CMD_PUS && dt_full) || (entry_op == CMD_POP && dt_empty);
`else
   assign guard_hit = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         depth   <= '0;
         err     <= 1'b0;
         dt_cmd  <= CMD_NON;
         dt_data <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  cnt_q  <= (req_cnt == 2'd0) ? 2'd1 : req_cnt;
                  data_q <= req_data;
                  if (req_op == CMD_NON) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (guard_hit) begin
                     err   <= 1'b1;
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= ISSUE;
                     dt_cmd  <= req_op;
                     dt_data <= (req_op == CMD_PUS) ? req_data : '0;
                  end
               end
            end
            ISSUE: begin
               if (dt_ack) begin
                  dt_cmd  <= CMD_NON;
                  dt_data <= '0;
                  case (op_q)
                     CMD_PUS: if (depth != DEPTH_MAX) depth <= depth + CNT_W'(1);
                     CMD_POP: if (depth != '0) depth <= depth - CNT_W'(1);
                     CMD_CLR: begin
                        depth <= '0;
                        err   <= 1'b0;
                     end
                     default: ;
                  endcase
                  if (op_q == CMD_POP && cnt_q > 2'd1) begin
                     cnt_q <= cnt_q - 2'd1;
                     state <= GAP;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (guard_hit) begin
                  err   <= 1'b1;
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state  <= ISSUE;
                  dt_cmd <= op_q;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dt_stack_seq.sv
// Randomized self-checking bench for dt_stack_seq against a transaction-level stack model.
// Honours DT_STACK_GUARD_EN in its model when the macro is defined for the build.
module tb_dt_stack_seq;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;

   logic              Clock = 1'b0;
   logic              Reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = '0;
   logic [1:0]        req_cnt = '0;
   logic [DATA_W-1:0] req_data = '0;
   logic [1:0]        dt_cmd;
   logic [DATA_W-1:0] dt_data;
   logic              dt_ack = 1'b0;
   logic [CNT_W-1:0]  dt_depth;
   logic              dt_empty;
   logic              dt_full;
   logic              done;
   logic              err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned m_depth  = 0;
   bit          m_err    = 1'b0;

   dt_stack_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .Clock(Clock), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_cnt(req_cnt), .req_data(req_data),
      .dt_cmd(dt_cmd), .dt_data(dt_data), .dt_ack(dt_ack),
      .dt_depth(dt_depth), .dt_empty(dt_empty), .dt_full(dt_full),
      .done(done), .err(err)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_depth"}, 64'(dt_depth), 64'(m_depth));
      check({tag, "_empty"}, 64'(dt_empty), 64'(m_depth == 0));
      check({tag, "_full"},  64'(dt_full),  64'(m_depth == DEPTH));
      check({tag, "_err"},   64'(err),      64'(m_err));
   endtask

   task automatic do_reset();
      Reset = 1'b1; req_valid = 1'b0; dt_ack = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      m_depth = 0; m_err = 1'b0;
      check("rst_ready", 64'(req_ready), 64'(1));
      check("rst_cmd",   64'(dt_cmd),    64'(0));
      check("rst_data",  64'(dt_data),   64'(0));
      check("rst_done",  64'(done),      64'(0));
      check_status("rst");
   endtask

   // One full request; the DUT is expected idle on entry. ack_dly = ISSUE cycles with ack low before the ack.
   task automatic run_req(input logic [1:0] op, input logic [1:0] cnt,
                          input logic [DATA_W-1:0] data, input int unsigned ack_dly);
      int unsigned reps;
      bit          blocked;
      logic [DATA_W-1:0] exp_data;
      reps = (op == 2'd2) ? ((cnt == 2'd0) ? 1 : int'(cnt)) : 1;
      exp_data = (op == 2'd1) ? data : '0;
      @(posedge Clock); #1;
      check("acc_ready", 64'(req_ready), 64'(1));
      check("acc_done",  64'(done),      64'(0));
      req_valid = 1'b1; req_op = op; req_cnt = cnt; req_data = data;
      dt_ack = 1'($urandom_range(0, 1));
      @(posedge Clock); #1;
      req_valid = 1'b0; req_op = 2'($urandom); req_cnt = 2'($urandom); req_data = $urandom;
      if (op != 2'd0) begin
         for (int unsigned r = 0; r < reps; r++) begin
            blocked = 1'b0;
`ifdef DT_STACK_GUARD_EN
            blocked = (op == 2'd1 && m_depth == DEPTH) || (op == 2'd2 && m_depth == 0);
`endif
            if (blocked) begin
               m_err = 1'b1;
               break;
            end
            for (int unsigned w = 0; w <= ack_dly; w++) begin
               check("iss_cmd",   64'(dt_cmd),    64'(op));
               check("iss_data",  64'(dt_data),   64'(exp_data));
               check("iss_ready", 64'(req_ready), 64'(0));
               check("iss_done",  64'(done),      64'(0));
               dt_ack = (w == ack_dly);
               @(posedge Clock); #1;
            end
            dt_ack = 1'($urandom_range(0, 1));
            case (op)
               2'd1: if (m_depth < DEPTH) m_depth++;
               2'd2: if (m_depth > 0) m_depth--;
               default: begin m_depth = 0; m_err = 1'b0; end
            endcase
            if (r + 1 < reps) begin
               check("gap_cmd",   64'(dt_cmd),    64'(0));
               check("gap_done",  64'(done),      64'(0));
               check("gap_ready", 64'(req_ready), 64'(0));
               check("gap_depth", 64'(dt_depth),  64'(m_depth));
               @(posedge Clock); #1;
            end
         end
      end
      check("dn_done",  64'(done),      64'(1));
      check("dn_cmd",   64'(dt_cmd),    64'(0));
      check("dn_data",  64'(dt_data),   64'(0));
      check("dn_ready", 64'(req_ready), 64'(0));
      check_status("dn");
   endtask

   initial begin
      logic [15:0] seq;
      int unsigned ncyc;
      bit          got_done;
      int unsigned k;

      do_reset();

      // Single PUSH, ack in the first ISSUE cycle
      run_req(2'd1, 2'd0, 32'h1234, 0);
      check("push1_empty", 64'(dt_empty), 64'(0));

      // Reset asserted while in GAP of a 2-deep POP
      @(posedge Clock); #1;
      check("rg_ready", 64'(req_ready), 64'(1));
      req_valid = 1'b1; req_op = 2'd2; req_cnt = 2'd2; dt_ack = 1'b0;
      @(posedge Clock); #1;
      req_valid = 1'b0;
      check("rg_cmd_pop", 64'(dt_cmd), 64'(2));
      dt_ack = 1'b1;
      @(posedge Clock); #1;
      check("rg_cmd_gap", 64'(dt_cmd), 64'(0));
      dt_ack = 1'b1; Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0; dt_ack = 1'b0;
      m_depth = 0; m_err = 1'b0;
      check("rg_cmd",   64'(dt_cmd),    64'(0));
      check("rg_done",  64'(done),      64'(0));
      check("rg_ready", 64'(req_ready), 64'(1));
      check_status("rg");

      // POP x3 with ack held high: command trace and acceptance-to-done latency
      for (int i = 0; i < 3; i++) run_req(2'd1, 2'd0, $urandom, 0);
      @(posedge Clock); #1;
      check("p3_ready", 64'(req_ready), 64'(1));
      req_valid = 1'b1; req_op = 2'd2; req_cnt = 2'd3; dt_ack = 1'b1;
      seq = '0; ncyc = 1; got_done = 1'b0;
      for (int i = 0; i < 20 && !got_done; i++) begin
         @(posedge Clock); #1;
         req_valid = 1'b0;
         ncyc++;
         if (done) got_done = 1'b1;
         else seq = {seq[13:0], dt_cmd};
      end
      dt_ack = 1'b0;
      m_depth = 0;
      check("p3_done_seen", 64'(got_done), 64'(1));
      check("p3_cmd_seq",   64'(seq),      64'(16'h0222));
      check("p3_latency",   64'(ncyc),     64'(7));
      check_status("p3");

      // POP x2 from empty, then CLEAR
      run_req(2'd2, 2'd2, $urandom, 0);
      run_req(2'd3, 2'd0, $urandom, 1);

      // Ack withheld for 10 cycles
      run_req(2'd1, 2'd0, 32'hCAFE_F00D, 10);

      // Fill to capacity, then one more PUSH
      while (m_depth < DEPTH) run_req(2'd1, 2'd0, $urandom, $urandom_range(0, 1));
      run_req(2'd1, 2'd0, 32'hDEAD_BEEF, 0);
      run_req(2'd2, 2'd1, $urandom, 0);
      run_req(2'd3, 2'd0, $urandom, 0);

      for (int i = 0; i < 150; i++) begin
         k = $urandom_range(0, 9);
         run_req((k == 0) ? 2'd0 : (k <= 5) ? 2'd1 : (k <= 8) ? 2'd2 : 2'd3,
                 2'($urandom), $urandom, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
